// File: rtl/dlc_pkg.sv
// Shared types and helpers for the delay-line trim controller.
// Frame length depends on the DLC_TRIM_PARITY_EN build macro.
package dlc_pkg;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_MUTE,
        ST_SETTLE,
        ST_RUN
    } dlc_state_e;

    function automatic int frame_len(input int channels, input int trim_w);
`ifdef DLC_TRIM_PARITY_EN
        return 2 * channels * trim_w + 1;
`else
        return 2 * channels * trim_w;
`endif
    endfunction

endpackage

// File: rtl/dlc_cfg_shift.sv
// Serial config shadow register, saturating bit counter, parity check.
// DLC_TRIM_PARITY_EN appends one even-parity bit to the frame.
module dlc_cfg_shift
    import dlc_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int TRIM_W   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sdi,
    input  logic                         sen,
    input  logic                         clr,
    output logic                         frame_ok,
    output logic [2*CHANNELS*TRIM_W-1:0] shadow,
    output logic                         sdo
);

    localparam int FRAME_W   = 2 * CHANNELS * TRIM_W;
    localparam int FRAME_LEN = frame_len(CHANNELS, TRIM_W);
    localparam int CNT_W     = $clog2(FRAME_LEN + 2);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_LEN + 1);

    logic [FRAME_LEN-1:0] sr;
    logic [CNT_W-1:0]     cnt;
    logic                 par_ok;

    // Shift when enabled; a latch edge clears the count and drops the shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr  <= '0;
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (sen) begin
            sr <= {sr[FRAME_LEN-2:0], sdi};
            if (cnt != CNT_SAT) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef DLC_TRIM_PARITY_EN
    assign par_ok = ~^sr;
`else
    assign par_ok = 1'b1;
`endif

    assign frame_ok = (cnt == CNT_FULL) & par_ok;
    assign shadow   = sr[FRAME_LEN-1 -: FRAME_W];
    assign sdo      = sr[FRAME_LEN-1];

endmodule

// File: rtl/dlc_trim_ctrl.sv
// Trim/enable controller: stages serial trims, commits with enables muted.
// Build option DLC_TRIM_PARITY_EN adds a parity bit to each frame.
module dlc_trim_ctrl
    import dlc_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int TRIM_W   = 4,
    parameter int SETTLE   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sdi,
    input  logic                       sen,
    input  logic                       latch,
    input  logic [CHANNELS-1:0]        sig,
    output logic                       sdo,
    output logic [CHANNELS*TRIM_W-1:0] trim_p,
    output logic [CHANNELS*TRIM_W-1:0] trim_n,
    output logic [CHANNELS-1:0]        en,
    output logic [CHANNELS-1:0]        sig_o,
    output logic                       busy,
    output logic                       cfg_err
);

    localparam int FRAME_W = 2 * CHANNELS * TRIM_W;
    localparam int SCNT_W  = $clog2(SETTLE + 1);

    localparam logic [SCNT_W-1:0] SCNT_LOAD = SCNT_W'(SETTLE - 1);

    logic               latch_q;
    logic               latch_edge;
    logic               frame_ok;
    logic               accept;
    logic [FRAME_W-1:0] shadow;
    logic [FRAME_W-1:0] staging;
    logic [SCNT_W-1:0]  scnt;
    dlc_state_e         state;

    assign latch_edge = latch & ~latch_q;
    assign accept     = latch_edge & frame_ok;

    dlc_cfg_shift #(
        .CHANNELS (CHANNELS),
        .TRIM_W   (TRIM_W)
    ) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .sdi      (sdi),
        .sen      (sen),
        .clr      (latch_edge),
        .frame_ok (frame_ok),
        .shadow   (shadow),
        .sdo      (sdo)
    );

    // Latch edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latch_q <= 1'b0;
        end else begin
            latch_q <= latch;
        end
    end

    // Stage accepted frames; every latch edge updates the sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staging <= '0;
            cfg_err <= 1'b0;
        end else if (latch_edge) begin
            cfg_err <= ~frame_ok;
            if (frame_ok) begin
                staging <= shadow;
            end
        end
    end

    // Commit FSM: mute, load trims, settle, then re-enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_OFF;
            scnt   <= '0;
            en     <= '0;
            busy   <= 1'b0;
            trim_p <= '0;
            trim_n <= '0;
        end else if (accept) begin
            state <= ST_MUTE;
            en    <= '0;
            busy  <= 1'b1;
        end else begin
            unique case (state)
                ST_MUTE: begin
                    state <= ST_SETTLE;
                    scnt  <= SCNT_LOAD;
                    for (int i = 0; i < CHANNELS; i++) begin
                        trim_p[i*TRIM_W +: TRIM_W] <=
                            staging[(2*i+1)*TRIM_W +: TRIM_W];
                        trim_n[i*TRIM_W +: TRIM_W] <=
                            staging[2*i*TRIM_W +: TRIM_W];
                    end
                end
                ST_SETTLE: begin
                    if (scnt == '0) begin
                        state <= ST_RUN;
                        en    <= '1;
                        busy  <= 1'b0;
                    end else begin
                        scnt <= scnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Gate the injection signal with the current enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_o <= '0;
        end else begin
            sig_o <= sig & en;
        end
    end

endmodule
